ula_serial: RTL and testbench
=============================

# ula_serial

Bit-serial ALU sequencer: accepts two WIDTH-bit operands and a 4-bit ALU control code, then drives one combinational 1-bit ALU slice LSB-first for WIDTH cycles. It feeds the slice's carry-out back as next carry-in and assembles the word result, including set-less-than from the MSB's set output. It also produces zero, signed-overflow and carry flags. It sits beside the datapath as a small-area replacement for a ripple array of 1-bit ALU slices, on the driving end of the slice's op/invert/carry/less interface.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- ctrl  in  4  {ainvert, binvert, op[1:0]}: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; captured on start
- busy  out  1  high from cycle after accept until done cycle inclusive
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  final word, held until next done
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow of MSB slice; 0 when op is 00 or 01
- carry_out  out  1  carry from MSB slice; 0 when op is 00 or 01

## Operation
- States: IDLE → RUN → FIN → IDLE.
- IDLE: start=1 captures a, b, ctrl into shift/control registers; bit counter ← 0; carry register ← binvert; go to RUN. start=0 holds IDLE.
- RUN, one bit per cycle, i = counter:
  - slice inputs: a_sh[0], b_sh[0], cin = carry reg, less = 0, ainvert/binvert/op from the captured ctrl;
  - slice result shifts into result_sh MSB (right shift); carry reg ← cout; a_sh, b_sh shift right.
  - At i = WIDTH-1, latch the slice's overflow, set and cout, then go to FIN.
- FIN: apply the final corrections, then go to IDLE:
  - if op = 11, result ← {WIDTH-1 zeros, set}; otherwise result ← result_sh;
  - zero, overflow, carry_out registered per port rules; done=1.
- Slice semantics:
  - A' = a ^ ainvert, B' = b ^ binvert; sum/cout full add of A', B', cin.
  - op: 00 A'&B', 01 A'|B', 10 sum, 11 less.
  - overflow = cin ^ cout; set = sum ^ overflow (sign-corrected).
- start in RUN/FIN is ignored; no queuing.
- Undefined ctrl combinations execute literally per the slice semantics; no error flag.
- Reset (any state, including mid-RUN): state IDLE, busy=0, done=0, result=0, zero=1, overflow=0, carry_out=0, internal shift registers and counter cleared; the operation in flight is discarded with no done.

## Timing
- Accept at edge k (start=1 in IDLE). RUN covers cycles k+1 … k+WIDTH. done=1 and outputs updated at edge k+WIDTH+1.
- Total latency is WIDTH+1 cycles. The earliest next accept is the edge following the done cycle, so throughput is one operation per WIDTH+2 cycles.
- busy rises at k+1 and falls with done.
- result/flags change only on the done edge or on reset.

## Structure
- Package ula_serial_pkg holds:
  - localparams for the six ctrl codes and the op field values (OP_AND, OP_OR, OP_ADD, OP_LESS);
  - the state encoding (IDLE, RUN, FIN).
- Sub-module ula_serial_slice: the combinational 1-bit slice above (ports a, b, less, cin, ainvert, binvert, op → result, cout, set, overflow), instantiated once.
- Top holds the FSM, counter (clog2(WIDTH) bits), shift registers and output registers.

## Test plan
- ADD a=0x7F, b=0x01, ctrl=0010 → done 9 cycles after accept; result=0x80, overflow=1, carry_out=0, zero=0.
- SUB a=0x05, b=0x05, ctrl=0110 → result=0x00, zero=1, carry_out=1, overflow=0.
- SLT a=0xFB, b=0x03 → result=0x01. SLT with overflow a=0x80, b=0x01 → result=0x01. SLT a=0x03, b=0xFB → result=0x00.
- Logic ops on a=0x0F, b=0xF0:
  - NOR (1100) → 0x00, zero=1;
  - OR (0001) → 0xFF;
  - AND (0000) → 0x00, overflow=0, carry_out=0.
- Hold start high continuously, changing a/b/ctrl mid-RUN → only the captured values are used; the next accept occurs exactly WIDTH+2 cycles after the previous one.
- Assert rst_n=0 at RUN bit 3 of an ADD → all outputs return to reset values immediately; no done pulse. A fresh ADD 0x01+0x01 afterwards → result=0x02.

Source files
------------

// File: rtl/ula_serial_pkg.sv
// Shared encodings for the bit-serial ALU sequencer.
package ula_serial_pkg;

  // Full 4-bit control codes: {ainvert, binvert, op[1:0]}
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  // Slice result selector
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/ula_serial_if.sv
// Request/result bundle between a datapath master and the serial ALU.
interface ula_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, a, b, ctrl,
    input  busy, done, result, zero, overflow, carry_out
  );

  modport slave (
    input  start, a, b, ctrl,
    output busy, done, result, zero, overflow, carry_out
  );
endinterface

// File: rtl/ula_serial_slice.sv
// Combinational 1-bit ALU slice with operand inversion and sign-corrected set.
module ula_serial_slice
  import ula_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       cin,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout,
  output logic       set,
  output logic       overflow
);

  logic aa, bb, sum;

  // Full add of the conditionally inverted operands, then result select
  always_comb begin
    aa       = a ^ ainvert;
    bb       = b ^ binvert;
    sum      = aa ^ bb ^ cin;
    cout     = (aa & bb) | (cin & (aa ^ bb));
    overflow = cin ^ cout;
    set      = sum ^ overflow;
    result   = 1'b0;
    case (op)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      OP_ADD:  result = sum;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/ula_serial.sv
// Bit-serial ALU: runs one slice LSB-first over WIDTH cycles, then registers result and flags.
module ula_serial
  import ula_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ula_serial_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, result_q, fin_word;
  logic [3:0]       ctrl_q;
  logic             carry_q, ovf_q, set_q, cout_q;
  logic             busy_q, done_q, zero_q, ovf_out_q, cout_out_q;
  logic             accept, last_bit, arith;
  logic             s_res, s_cout, s_set, s_ovf;

  ula_serial_slice u_slice (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .less     (1'b0),
    .cin      (carry_q),
    .ainvert  (ctrl_q[3]),
    .binvert  (ctrl_q[2]),
    .op       (ctrl_q[1:0]),
    .result   (s_res),
    .cout     (s_cout),
    .set      (s_set),
    .overflow (s_ovf)
  );

  // Next-state and step decode
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (cnt_q == LAST) begin
        last_bit = 1'b1;
        state_d  = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final word and flag qualification from the captured op
  always_comb begin
    arith    = (ctrl_q[1:0] == OP_ADD) || (ctrl_q[1:0] == OP_LESS);
    fin_word = res_sh;
    if (ctrl_q[1:0] == OP_LESS)
      fin_word = {{(WIDTH-1){1'b0}}, set_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture, serial shift and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      ctrl_q     <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      set_q      <= 1'b0;
      cout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      ovf_out_q  <= 1'b0;
      cout_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= accept;
          if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            ctrl_q  <= bus.ctrl;
            carry_q <= bus.ctrl[2];
            cnt_q   <= '0;
          end
        end
        RUN: begin
          res_sh  <= {s_res, res_sh[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= s_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            ovf_q  <= s_ovf;
            set_q  <= s_set;
            cout_q <= s_cout;
          end
        end
        FIN: begin
          result_q   <= fin_word;
          zero_q     <= (fin_word == '0);
          ovf_out_q  <= arith & ovf_q;
          cout_out_q <= arith & cout_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_out_q;
  assign bus.carry_out = cout_out_q;

endmodule

// File: tb/tb_ula_serial.sv
// Directed bench for the bit-serial ALU sequencer.
module tb_ula_serial;
  import ula_serial_pkg::*;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ula_serial_if #(.WIDTH(W)) bus ();

  ula_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [3:0] ctrl;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       v;
    logic       c;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   32'(bus.busy), 0);
    chk({tag, "_done"},   32'(bus.done), 0);
    chk({tag, "_result"}, 32'(bus.result), 0);
    chk({tag, "_zero"},   32'(bus.zero), 1);
    chk({tag, "_ovf"},    32'(bus.overflow), 0);
    chk({tag, "_cout"},   32'(bus.carry_out), 0);
  endtask

  task automatic run_op(input string nm, input logic [3:0] ctrl, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic z,
                        input logic v, input logic c);
    int n;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.ctrl  = ctrl;
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    chk({nm, "_busy_rise"}, 32'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_latency"},  n, W + 1);
    chk({nm, "_busy_done"}, 32'(bus.busy), 1);
    chk({nm, "_result"},   32'(bus.result), 32'(res));
    chk({nm, "_zero"},     32'(bus.zero), 32'(z));
    chk({nm, "_ovf"},      32'(bus.overflow), 32'(v));
    chk({nm, "_cout"},     32'(bus.carry_out), 32'(c));
    tick();
    chk({nm, "_done_pulse"}, 32'(bus.done), 0);
    chk({nm, "_busy_fall"},  32'(bus.busy), 0);
    chk({nm, "_hold"},       32'(bus.result), 32'(res));
  endtask

  initial begin
    int n;
    int done_seen;
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ctrl  = '0;
    rst_n     = 1'b1;

    vecs[0]  = '{"add_7f_01", CTRL_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"sub_05_05", CTRL_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"slt_fb_03", CTRL_SLT, 8'hFB, 8'h03, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{"slt_80_01", CTRL_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{"slt_03_fb", CTRL_SLT, 8'h03, 8'hFB, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"nor_0f_f0", CTRL_NOR, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"or_0f_f0",  CTRL_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"and_0f_f0", CTRL_AND, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"add_ff_01", CTRL_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"sub_80_01", CTRL_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"add_c0_c0", CTRL_ADD, 8'hC0, 8'hC0, 8'h80, 1'b0, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].z, vecs[i].v, vecs[i].c);

    // start held high with inputs churning mid-operation
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.ctrl  = CTRL_ADD;
    tick();
    n = 0;
    while (!bus.done && n < 40) begin
      bus.a    = 8'(n * 37 + 5);
      bus.b    = 8'(n * 91 + 3);
      bus.ctrl = (n % 2 == 0) ? CTRL_SUB : CTRL_OR;
      tick();
      n++;
    end
    chk("hold1_latency", n, W + 1);
    chk("hold1_result", 32'(bus.result), 32'h02);
    bus.a    = 8'h10;
    bus.b    = 8'h20;
    bus.ctrl = CTRL_ADD;
    tick();
    n = 0;
    while (!bus.done && n < 40) begin
      bus.a    = 8'(n * 53 + 7);
      bus.b    = 8'(n * 29 + 1);
      bus.ctrl = (n % 2 == 0) ? CTRL_NOR : CTRL_SLT;
      tick();
      n++;
    end
    chk("hold2_latency", n, W + 1);
    chk("hold2_result", 32'(bus.result), 32'h30);
    bus.start = 1'b0;
    tick();
    chk("hold_busy_fall", 32'(bus.busy), 0);

    // reset while bit 3 of an ADD is in the slice
    bus.start = 1'b1;
    bus.a     = 8'h7F;
    bus.b     = 8'h01;
    bus.ctrl  = CTRL_ADD;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("midrun_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun_reset");
    tick();
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    chk("midrun_no_done", done_seen, 0);
    chk("midrun_idle_busy", 32'(bus.busy), 0);
    run_op("post_reset_add", CTRL_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
